booth_seq_mult: RTL and testbench

Parametrised sequential radix-4 Booth multiplier, the multi-cycle successor to the single-cycle 32×32 Booth array. It retires two multiplier bits per clock and supports signed and unsigned operands selected per operation. Operations are started and completed through a start/busy/done handshake. It sits in the datapath's MUL/DIV unit and drives the HI/LO result pair.

---
 rtl/booth_seq_mult.sv | 120 ++++++++++++
 tb/tb_booth_seq_mult.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per clock,
// signed or unsigned per operation, start/busy/done handshake.
module booth_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Result,
  output logic [1:0]           dbg_state_o
);

  localparam int AW = WIDTH + 4;      // accumulator width, absorbs +/-2M
  localparam int XW = WIDTH + 2;      // extended operand width
  localparam int N  = WIDTH / 2 + 1;  // iterations per multiply
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [XW-1:0]        q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [XW-1:0]        m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [AW-1:0]        m_ext, m_dbl, addend, sum, acc_sh;
  logic [XW-1:0]        q_sh;
  logic [2:0]           triple;

  // Datapath for one Booth step: add recoded multiple, then arithmetic shift by 2.
  always_comb begin
    m_ext  = {{2{m_q[XW-1]}}, m_q};
    m_dbl  = {m_ext[AW-2:0], 1'b0};
    triple = {q_q[1:0], qm1_q};
    addend = '0;
    case (triple)
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_dbl;
      3'b100:         addend = AW'(0) - m_dbl;
      3'b101, 3'b110: addend = AW'(0) - m_ext;
      default:        addend = '0;
    endcase
    sum    = acc_q + addend;
    acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_sh   = {sum[1:0], q_q[XW-1:2]};
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          acc_d   = '0;
          qm1_d   = 1'b0;
          m_d     = {{2{signed_mode & M[WIDTH-1]}}, M};
          q_d     = {{2{signed_mode & Q[WIDTH-1]}}, Q};
          cnt_d   = CW'(N);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Exact product always fits in the low 2*WIDTH bits of {acc, q}.
          result_d = {acc_sh[WIDTH-3:0], q_sh};
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign Result      = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and swept checks of booth_seq_mult at WIDTH=32 and WIDTH=8,
// covering products, latency, the start/busy/done handshake and reset.
module tb_booth_seq_mult;

  logic        clk;
  logic        clear_n;

  logic        start32, sm32, busy32, done32;
  logic [31:0] m32, q32;
  logic [63:0] res32;
  logic [1:0]  dbg32;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] res8;
  logic [1:0]  dbg8;

  int tests;
  int fails;
  logic [63:0] exp_q[$];

  booth_seq_mult #(.WIDTH(32)) dut32 (
    .clock(clk), .clear_n(clear_n), .start(start32), .signed_mode(sm32),
    .M(m32), .Q(q32), .busy(busy32), .done(done32), .Result(res32),
    .dbg_state_o(dbg32)
  );

  booth_seq_mult #(.WIDTH(8)) dut8 (
    .clock(clk), .clear_n(clear_n), .start(start8), .signed_mode(sm8),
    .M(m8), .Q(q8), .busy(busy8), .done(done8), .Result(res8),
    .dbg_state_o(dbg8)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge. Done is expected N+1 negedges later (Result loads at
  // edge e0+N). poke_cyc > 0 pulses a spurious start in that busy cycle.
  task automatic run32(input logic sm, input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp, input string name,
                       input bit hold_chk, input logic [63:0] hold_val, input int poke_cyc);
    int cyc;
    bit busy_ok, hold_ok;
    start32 = 1'b1; sm32 = sm; m32 = m; q32 = q;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    m32 = $urandom(); q32 = $urandom(); sm32 = ~sm;
    cyc = 1; busy_ok = 1; hold_ok = 1;
    while (!done32 && cyc <= 40) begin
      if (!busy32) busy_ok = 0;
      if (hold_chk && res32 !== hold_val) hold_ok = 0;
      if (cyc == poke_cyc) begin
        start32 = 1'b1; m32 = 32'h1234_5678; q32 = 32'h0000_0003;
      end else begin
        start32 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start32 = 1'b0;
    if (!done32) begin
      check({name, " timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end else begin
      check({name, " latency"}, 64'(cyc), 64'd18);
      check({name, " busy"}, {63'd0, busy_ok & ~busy32}, 64'd1);
      check({name, " result"}, res32, exp_q.pop_front());
      if (hold_chk) check({name, " hold"}, {63'd0, hold_ok}, 64'd1);
    end
  endtask

  task automatic run8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] exp, input string name);
    int cyc;
    start8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
    exp_q.push_back({48'd0, exp});
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; m8 = 8'($urandom()); q8 = 8'($urandom());
    cyc = 1;
    while (!done8 && cyc <= 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!done8) begin
      check({name, " timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end else begin
      check({name, " latency"}, 64'(cyc), 64'd6);
      check({name, " result"}, {48'd0, res8}, exp_q.pop_front());
    end
  endtask

  // Counts done pulses over n cycles; none are expected.
  task automatic quiet32(input int n, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done32) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0]  sa, sb;
    logic signed [17:0] p;
    sa = $signed({sm & a[7], a});
    sb = $signed({sm & b[7], b});
    p  = sa * sb;
    return p[15:0];
  endfunction

  typedef struct {
    logic        sm;
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] exp;
  } vec32_t;

  vec32_t vecs[10];

  initial begin
    logic [63:0] first;
    logic        rsm;
    logic [7:0]  ra, rb;

    tests = 0; fails = 0;
    vecs[0] = '{1'b1, 32'hFFFF_FFCB, 32'hFFFF_FFC2, 64'h0000_0000_0000_0CD6};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[6] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[7] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};
    vecs[9] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};

    // Reset
    clear_n = 1'b0;
    start32 = 1'b0; sm32 = 1'b0; m32 = '0; q32 = '0;
    start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    check("reset busy", {63'd0, busy32}, 64'd0);
    check("reset done", {63'd0, done32}, 64'd0);
    check("reset result", res32, 64'd0);
    check("reset state", {62'd0, dbg32}, 64'd0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run32(vecs[i].sm, vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i), 1'b0, 64'd0, 0);
      @(negedge clk);
    end

    // Spurious start mid-RUN is ignored; no extra done afterwards.
    run32(1'b1, 32'hFFFF_FFCB, 32'hFFFF_FFC2, 64'h0CD6, "ignore_start", 1'b0, 64'd0, 5);
    quiet32(25, "ignore_start no extra done");

    // Back-to-back: second start in the done cycle, first Result held meanwhile.
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "b2b_a", 1'b0, 64'd0, 0);
    first = 64'hFFFF_FFFE_0000_0001;
    run32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "b2b_b", 1'b1, first, 0);
    @(negedge clk);

    // Reset during iteration 5 discards the op.
    start32 = 1'b1; sm32 = 1'b1; m32 = 32'h0000_0007; q32 = 32'h0000_0009;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    check("midrun reset busy", {63'd0, busy32}, 64'd0);
    check("midrun reset done", {63'd0, done32}, 64'd0);
    check("midrun reset result", res32, 64'd0);
    quiet32(25, "midrun reset no done");
    run32(1'b1, 32'h0000_0007, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFC1, "after_reset", 1'b0, 64'd0, 0);
    @(negedge clk);

    // WIDTH=8 instance
    run8(1'b1, 8'h80, 8'h7F, 16'hC080, "w8 signed");
    @(negedge clk);
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8 unsigned");
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      rsm = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      run8(rsm, ra, rb, ref8(rsm, ra, rb), $sformatf("w8 sweep%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
